// File: rtl/poci_serializer.sv
// SPI read-path (POCI) serializer: captures the frame's address byte from PICO,
// then streams register bytes MSB first from that address with auto-increment.
module poci_serializer #(
    parameter int                DATA_W   = 8,
    parameter int                MAX_ADDR = 59,
    parameter logic [DATA_W-1:0] FILL     = '0
) (
    input  logic              sclk,
    input  logic              rstn,
    input  logic              frame_en,
    input  logic              serial_in,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] rd_addr,
    output logic              serial_out,
    output logic              out_en,
    output logic              byte_done
);

    localparam int CW = $clog2(DATA_W);
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, ADDR, TURN, DATA} state_t;

    state_t            state, state_n;
    logic [DATA_W-1:0] addr_ptr, addr_ptr_n;
    logic [DATA_W-1:0] shreg, shreg_n;
    logic [DATA_W-1:0] addr_sr, addr_sr_n;
    logic [CW-1:0]     bit_cnt, bit_cnt_n;
    logic              done_q, done_n;
    logic [DATA_W-1:0] load_val;

    // Out-of-range addresses read back as FILL instead of whatever the mux returns.
    assign load_val = (addr_ptr > DATA_W'(MAX_ADDR)) ? FILL : rd_data;

    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            addr_ptr <= '0;
            shreg    <= '0;
            addr_sr  <= '0;
            bit_cnt  <= '0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_n;
            addr_ptr <= addr_ptr_n;
            shreg    <= shreg_n;
            addr_sr  <= addr_sr_n;
            bit_cnt  <= bit_cnt_n;
            done_q   <= done_n;
        end
    end

    always_comb begin
        state_n    = state;
        addr_ptr_n = addr_ptr;
        shreg_n    = shreg;
        addr_sr_n  = addr_sr;
        bit_cnt_n  = bit_cnt;
        done_n     = 1'b0;
        if (!frame_en) begin
            // addr_ptr deliberately holds across frames
            state_n   = IDLE;
            shreg_n   = '0;
            bit_cnt_n = '0;
        end else begin
            case (state)
                IDLE: begin
                    addr_sr_n = {{(DATA_W-1){1'b0}}, serial_in};
                    bit_cnt_n = CW'(1);
                    state_n   = ADDR;
                end
                ADDR: begin
                    addr_sr_n = {addr_sr[DATA_W-2:0], serial_in};
                    if (bit_cnt == LAST) begin
                        addr_ptr_n = addr_sr_n;
                        bit_cnt_n  = '0;
                        state_n    = TURN;
                    end else begin
                        bit_cnt_n = bit_cnt + 1'b1;
                    end
                end
                TURN: begin
                    shreg_n    = load_val;
                    addr_ptr_n = addr_ptr + 1'b1;
                    bit_cnt_n  = '0;
                    state_n    = DATA;
                end
                DATA: begin
                    // Reload on the last bit edge so bytes run back-to-back.
                    if (bit_cnt == LAST) begin
                        shreg_n    = load_val;
                        addr_ptr_n = addr_ptr + 1'b1;
                        bit_cnt_n  = '0;
                        done_n     = 1'b1;
                    end else begin
                        shreg_n   = shreg << 1;
                        bit_cnt_n = bit_cnt + 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign rd_addr    = addr_ptr;
    assign serial_out = shreg[DATA_W-1];
    assign out_en     = (state == TURN) || (state == DATA);
    assign byte_done  = done_q;

endmodule

// File: tb/tb_poci_serializer.sv
// Bench for poci_serializer: table-driven frames, hand-written drop/reset cases,
// and random frames checked edge-by-edge against a frame-level reference model.
module tb_poci_serializer;

    logic       sclk = 1'b0;
    logic       rstn;
    logic       frame_en;
    logic       serial_in;
    logic [7:0] rd_data;
    logic [7:0] rd_addr;
    logic       serial_out;
    logic       out_en;
    logic       byte_done;

    logic [7:0] mem [256];
    logic [7:0] model_ptr;
    logic [7:0] got_b [4];
    int         pulses;
    int         n_cmp = 0;
    int         n_err = 0;

    poci_serializer #(.DATA_W(8), .MAX_ADDR(59), .FILL(8'h00)) dut (
        .sclk(sclk), .rstn(rstn), .frame_en(frame_en), .serial_in(serial_in),
        .rd_data(rd_data), .rd_addr(rd_addr), .serial_out(serial_out),
        .out_en(out_en), .byte_done(byte_done)
    );

    assign rd_data = mem[rd_addr];

    always #5 sclk = ~sclk;

    typedef struct {
        logic [7:0] addr;
        int         n_hi;
        int         nbytes;
        logic [7:0] exp_b [3];
        int         exp_pulses;
        logic [7:0] exp_end;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    function automatic logic [7:0] ld(input logic [7:0] x);
        return (x > 8'd59) ? 8'h00 : mem[x];
    endfunction

    task automatic chk_outs(input string tag, input logic eo, input logic es,
                            input logic ed, input logic [7:0] ea);
        chk({tag, " out_en"}, out_en, eo);
        chk({tag, " serial_out"}, serial_out, es);
        chk({tag, " byte_done"}, byte_done, ed);
        chk({tag, " rd_addr"}, rd_addr, ea);
    endtask

    // Drives one frame of n_hi frame_en-high edges; the model derives every edge's
    // outputs from the frame address and edge position alone.
    task automatic run_frame(input logic [7:0] a, input int n_hi, input bit drop);
        pulses = 0;
        for (int i = 0; i < 4; i++) got_b[i] = 8'h00;
        for (int e = 1; e <= n_hi; e++) begin
            logic       es, ed, eo;
            logic [7:0] byt;
            int         j;
            frame_en  = 1'b1;
            serial_in = (e <= 8) ? a[8-e] : 1'($urandom % 2);
            tick();
            if (e <= 7) begin
                eo = 0; es = 0; ed = 0;
            end else if (e == 8) begin
                eo = 1; es = 0; ed = 0;
                model_ptr = a;
            end else begin
                j   = e - 9;
                byt = ld(a + 8'(j / 8));
                eo  = 1;
                es  = byt[7 - (j % 8)];
                ed  = (j > 0) && (j % 8 == 0);
                model_ptr = a + 8'(1 + j / 8);
                if (j < 32) got_b[j/8][7 - (j % 8)] = serial_out;
                if (byte_done) pulses++;
            end
            chk_outs($sformatf("a%02h e%0d", a, e), eo, es, ed, model_ptr);
        end
        if (drop) begin
            frame_en = 1'b0;
            tick();
            chk_outs($sformatf("a%02h drop", a), 1'b0, 1'b0, 1'b0, model_ptr);
        end
    endtask

    vec_t vecs [5];

    initial begin
        vecs[0] = '{addr: 8'h05, n_hi: 33, nbytes: 3, exp_b: '{8'h15, 8'h16, 8'h17}, exp_pulses: 3, exp_end: 8'h09};
        vecs[1] = '{addr: 8'h3B, n_hi: 24, nbytes: 2, exp_b: '{8'h4B, 8'h00, 8'h00}, exp_pulses: 1, exp_end: 8'h3D};
        vecs[2] = '{addr: 8'hFF, n_hi: 24, nbytes: 2, exp_b: '{8'h00, 8'h10, 8'h00}, exp_pulses: 1, exp_end: 8'h01};
        vecs[3] = '{addr: 8'h00, n_hi: 17, nbytes: 1, exp_b: '{8'h10, 8'h00, 8'h00}, exp_pulses: 1, exp_end: 8'h02};
        vecs[4] = '{addr: 8'h3A, n_hi: 25, nbytes: 2, exp_b: '{8'h4A, 8'h4B, 8'h00}, exp_pulses: 2, exp_end: 8'h3D};

        for (int i = 0; i < 256; i++) mem[i] = 8'(i + 8'h10);
        rstn      = 1'b0;
        frame_en  = 1'b0;
        serial_in = 1'b0;
        model_ptr = 8'h00;
        #1;
        chk_outs("reset", 1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        tick();
        @(negedge sclk);
        rstn = 1'b1;
        tick();
        chk_outs("idle", 1'b0, 1'b0, 1'b0, 8'h00);

        // Table frames: n_hi = 8 address + 1 turn + data edges
        foreach (vecs[v]) begin
            run_frame(vecs[v].addr, vecs[v].n_hi, 1'b1);
            for (int b = 0; b < vecs[v].nbytes; b++)
                chk($sformatf("vec%0d byte%0d", v, b), got_b[b], vecs[v].exp_b[b]);
            chk($sformatf("vec%0d pulses", v), pulses, vecs[v].exp_pulses);
            chk($sformatf("vec%0d end rd_addr", v), rd_addr, vecs[v].exp_end);
        end

        // Frame dropped after data bit 3 of byte 0, then a clean frame at 0x04
        run_frame(8'h20, 13, 1'b1);
        chk("drop pulses", pulses, 0);
        run_frame(8'h04, 17, 1'b1);
        chk("after drop byte0", got_b[0], 8'h14);

        // Async reset while bit 5 of the first data byte is on the line
        run_frame(8'h07, 11, 1'b0);
        chk("pre-reset serial_out", serial_out, mem[7][5]);
        #2 rstn = 1'b0;
        #1;
        model_ptr = 8'h00;
        chk_outs("async reset", 1'b0, 1'b0, 1'b0, 8'h00);
        frame_en = 1'b0;
        @(negedge sclk);
        rstn = 1'b1;
        tick();
        chk_outs("post reset idle", 1'b0, 1'b0, 1'b0, 8'h00);
        run_frame(8'h09, 25, 1'b1);
        chk("post reset byte0", got_b[0], 8'h19);
        chk("post reset byte1", got_b[1], 8'h1A);

        // Random register contents, addresses biased toward the MAX_ADDR and wrap edges
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        for (int f = 0; f < 30; f++) begin
            logic [7:0] a;
            case ($urandom % 4)
                0: a = 8'($urandom);
                1: a = 8'($urandom_range(57, 61));
                2: a = 8'($urandom_range(253, 255));
                default: a = 8'($urandom_range(0, 3));
            endcase
            run_frame(a, $urandom_range(1, 40), 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
